// File: rtl/tt_um_serial_adder_if.sv
// Tiny Tapeout user-slot pin bundle for the serial adder.
interface tt_um_serial_adder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_serial_adder.sv
// Digit-serial A+B / A-B with byte-loaded operands; DIGIT bits per cycle.
// Optional signed-overflow flag on uio[4] when SADD_OVF_EN is defined.
module tt_um_serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tt_um_serial_adder_if.slave  bus
);
    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   a, a_d, b, b_d;
    logic [WIDTH-1:0]   sa, sa_d, sb, sb_d;
    logic [WIDTH-1:0]   wres, wres_d, res, res_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               carry_w, carry_w_d, carry_f, carry_f_d;
    logic               busy, busy_d, done, done_d;
    logic               start_q;
    logic [DIGIT:0]     sum_ext_c;
    logic               start_pulse_c, accept_start_c, accept_load_c, finish_c;
    logic               ovf_bit;
    logic               unused_pins;

    assign unused_pins = &{1'b0, bus.ena, bus.ui_in, bus.uio_in};

    assign start_pulse_c = bus.uio_in[2] & ~start_q;
    assign sum_ext_c = (DIGIT+1)'(sa[DIGIT-1:0]) + (DIGIT+1)'(sb[DIGIT-1:0])
                     + (DIGIT+1)'(carry_w);

    // Next-state and datapath update
    always_comb begin
        state_d        = state;
        a_d            = a;
        b_d            = b;
        sa_d           = sa;
        sb_d           = sb;
        wres_d         = wres;
        res_d          = res;
        cnt_d          = cnt;
        carry_w_d      = carry_w;
        carry_f_d      = carry_f;
        busy_d         = busy;
        done_d         = done;
        accept_start_c = 1'b0;
        accept_load_c  = 1'b0;
        finish_c       = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse_c) begin
                    accept_start_c = 1'b1;
                    sa_d      = a;
                    sb_d      = bus.uio_in[3] ? ~b : b;
                    carry_w_d = bus.uio_in[3];
                    wres_d    = '0;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else if (bus.uio_in[0] || bus.uio_in[1]) begin
                    accept_load_c = 1'b1;
                    if (bus.uio_in[0]) a_d = bus.ui_in[WIDTH-1:0];
                    if (bus.uio_in[1]) b_d = bus.ui_in[WIDTH-1:0];
                    done_d = 1'b0;
                end
            end
            RUN: begin
                sa_d      = sa >> DIGIT;
                sb_d      = sb >> DIGIT;
                carry_w_d = sum_ext_c[DIGIT];
                cnt_d     = cnt + CNT_W'(1);
                // Sum digit enters from the MSB so the result lands aligned after NDIG shifts
                wres_d    = (wres >> DIGIT) | (WIDTH'(sum_ext_c[DIGIT-1:0]) << (WIDTH - DIGIT));
                if (cnt == CNT_W'(NDIG - 1)) begin
                    finish_c  = 1'b1;
                    res_d     = wres_d;
                    carry_f_d = sum_ext_c[DIGIT];
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            sa      <= '0;
            sb      <= '0;
            wres    <= '0;
            res     <= '0;
            cnt     <= '0;
            carry_w <= 1'b0;
            carry_f <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_d;
            a       <= a_d;
            b       <= b_d;
            sa      <= sa_d;
            sb      <= sb_d;
            wres    <= wres_d;
            res     <= res_d;
            cnt     <= cnt_d;
            carry_w <= carry_w_d;
            carry_f <= carry_f_d;
            busy    <= busy_d;
            done    <= done_d;
            start_q <= bus.uio_in[2];
        end
    end

`ifdef SADD_OVF_EN
    logic sub_q, sub_d, ovf, ovf_d;
    logic bop_msb_c;

    assign bop_msb_c = sub_q ? ~b[WIDTH-1] : b[WIDTH-1];

    // Signed overflow: effective operand signs agree but the result sign differs from A
    always_comb begin
        sub_d = sub_q;
        ovf_d = ovf;
        if (accept_start_c) begin
            sub_d = bus.uio_in[3];
            ovf_d = 1'b0;
        end else if (accept_load_c) begin
            ovf_d = 1'b0;
        end else if (finish_c) begin
            ovf_d = (a[WIDTH-1] == bop_msb_c) && (wres_d[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            sub_q <= sub_d;
            ovf   <= ovf_d;
        end
    end

    assign ovf_bit    = ovf;
    assign bus.uio_oe = 8'b1111_0000;
`else
    assign ovf_bit    = 1'b0;
    assign bus.uio_oe = 8'b1110_0000;
`endif

    assign bus.uo_out  = 8'(res);
    assign bus.uio_out = {carry_f, done, busy, ovf_bit, 4'b0000};
endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Directed table-driven bench running three parametrisations on shared stimulus.
module tb_tt_um_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui = 8'h00;
    logic [7:0] uio = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tt_um_serial_adder_if b81 ();
    tt_um_serial_adder_if b84 ();
    tt_um_serial_adder_if b42 ();

    assign b81.ena = 1'b1;  assign b81.ui_in = ui;  assign b81.uio_in = uio;
    assign b84.ena = 1'b1;  assign b84.ui_in = ui;  assign b84.uio_in = uio;
    assign b42.ena = 1'b1;  assign b42.ui_in = ui;  assign b42.uio_in = uio;

    tt_um_serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .rst_n(rst_n), .bus(b81));
    tt_um_serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst_n(rst_n), .bus(b84));
    tt_um_serial_adder #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst_n(rst_n), .bus(b42));

`ifdef SADD_OVF_EN
    localparam logic [7:0] OE_EXP = 8'hF0;
    localparam bit OVF_ON = 1'b1;
`else
    localparam logic [7:0] OE_EXP = 8'hE0;
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         sub;
        logic [7:0] r8;
        bit         c8;
        bit         v8;
        logic [7:0] r4;
        bit         c4;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Load A then B on consecutive edges, then start; returns cycles until done per DUT
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit sub,
                          output int l81, output int l84, output int l42);
        @(negedge clk); ui = a; uio = 8'h01;
        @(negedge clk); ui = b; uio = 8'h02;
        @(negedge clk); ui = 8'h00; uio = {4'b0, sub, 3'b100};
        l81 = -1; l84 = -1; l42 = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("busy_after_start", {7'b0, b81.uio_out[5]}, 8'h01);
                uio = 8'h00;
            end
            if (b81.uio_out[6] && l81 < 0) l81 = k;
            if (b84.uio_out[6] && l84 < 0) l84 = k;
            if (b42.uio_out[6] && l42 < 0) l42 = k;
        end
    endtask

    initial begin
        int l81, l84, l42;
        logic [7:0] ov;
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 8'h08, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h0E, 1'b0};
        vecs[3] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 8'h02, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h0F, 1'b0};
        vecs[6] = '{8'h9C, 8'h64, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h0F, 8'h02, 1'b0, 8'h11, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[8] = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};

        // Reset state
        #2;
        chk("rst_uo_81", b81.uo_out, 8'h00);
        chk("rst_uio_81", b81.uio_out, 8'h00);
        chk("rst_oe_81", b81.uio_oe, OE_EXP);
        chk("rst_uo_42", b42.uo_out, 8'h00);
        chk("rst_oe_42", b42.uio_oe, OE_EXP);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, l81, l84, l42);
            ov = (OVF_ON && vecs[i].v8) ? 8'h10 : 8'h00;
            chk($sformatf("v%0d_lat_81", i), 8'(l81), 8'd8);
            chk($sformatf("v%0d_lat_84", i), 8'(l84), 8'd2);
            chk($sformatf("v%0d_lat_42", i), 8'(l42), 8'd2);
            chk($sformatf("v%0d_uo_81", i), b81.uo_out, vecs[i].r8);
            chk($sformatf("v%0d_uio_81", i), b81.uio_out, {vecs[i].c8, 2'b10, 5'b0} | ov);
            chk($sformatf("v%0d_uo_84", i), b84.uo_out, vecs[i].r8);
            chk($sformatf("v%0d_uio_84", i), b84.uio_out, {vecs[i].c8, 2'b10, 5'b0} | ov);
            chk($sformatf("v%0d_uo_42", i), b42.uo_out, vecs[i].r4);
            chk($sformatf("v%0d_c_42", i), {7'b0, b42.uio_out[7]}, {7'b0, vecs[i].c4});
        end

        // A load clears done and leaves result untouched
        @(negedge clk); ui = 8'h33; uio = 8'h01;
        @(negedge clk); uio = 8'h00;
        chk("load_clears_done", {7'b0, b81.uio_out[6]}, 8'h00);
        chk("load_keeps_uo", b81.uo_out, 8'h00);

        // Disturbances during RUN must not affect the W8/D1 instance
        @(negedge clk); ui = 8'h05; uio = 8'h01;
        @(negedge clk); ui = 8'h03; uio = 8'h02;
        @(negedge clk); ui = 8'h00; uio = 8'h04;
        l81 = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b81.uio_out[6] && l81 < 0) l81 = k;
            if (k < 7) begin
                if (k > 0) chk("run_uo_hold", b81.uo_out, 8'h00);
                ui  = 8'hAA;
                uio = (k % 2 == 0) ? 8'h08 : 8'h0F;
            end else begin
                uio = 8'h00;
            end
        end
        chk("dist_lat_81", 8'(l81), 8'd8);
        chk("dist_uo_81", b81.uo_out, 8'h08);
        chk("dist_c_81", {7'b0, b81.uio_out[7]}, 8'h00);

        // Start held high across completion must not retrigger
        @(negedge clk); ui = 8'h01; uio = 8'h03;
        @(negedge clk); uio = 8'h04;
        l81 = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (b81.uio_out[6] && l81 < 0) l81 = k;
            if (k > 8) chk("held_no_rerun", b81.uio_out[6:5], 8'h02);
        end
        uio = 8'h00;
        chk("held_lat", 8'(l81), 8'd8);
        chk("held_uo", b81.uo_out, 8'h02);

        // Asynchronous reset mid-RUN at digit 3
        @(negedge clk); ui = 8'h05; uio = 8'h01;
        @(negedge clk); ui = 8'h03; uio = 8'h02;
        @(negedge clk); uio = 8'h04;
        repeat (3) @(negedge clk);
        uio = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_uo_81", b81.uo_out, 8'h00);
        chk("midrst_uio_81", b81.uio_out, 8'h00);
        chk("midrst_oe_81", b81.uio_oe, OE_EXP);
        chk("midrst_uio_84", b84.uio_out, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", b81.uio_out, 8'h00);
        chk("midrst_uo_after", b81.uo_out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tt_um_serial_adder.md
# tt_um_serial_adder

Multi-cycle, parametrised successor to the team's single-bit half adder. Operands are loaded byte-wise through `ui_in` under strobes on `uio_in`. A digit-serial ripple datapath then computes A+B or A−B, DIGIT bits per cycle, with carry chained between cycles. The result, carry and status flags are presented on `uo_out` and the upper `uio` pins. The block sits directly in the Tiny Tapeout user slot.

## Interface
- `WIDTH`, default 8: operand/result width; legal 2..8.
- `DIGIT`, default 1: bits added per cycle; must divide WIDTH.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: ignored.
- `ui_in` in 8: data byte; bits [WIDTH-1:0] used, the rest ignored.
- `uio_in` in 8 (bits 4..0 used):
  - [0] load_a: level; loads A.
  - [1] load_b: level; loads B.
  - [2] start: rising-edge trigger.
  - [3] sub: 1 = A−B, 0 = A+B; sampled at start.
  - [4] unused.
- `uo_out` out 8: result register; bits [7:WIDTH] are always 0.
- `uio_out` out 8:
  - [5] busy.
  - [6] done.
  - [7] carry. For add: carry out. For sub: 1 = no borrow.
  - [4]: see Configuration.
  - All other bits are 0.
- `uio_oe` out 8: constant 8'b1110_0000, or 8'b1111_0000 with the macro.

## Operation
- States: IDLE, RUN.
- IDLE:
  - load_a=1 at an edge: A ← ui_in[WIDTH-1:0].
  - load_b=1 at an edge: B ← ui_in[WIDTH-1:0].
  - Both high: both registers get the same byte.
  - Any load clears done.
- Start is detected as start=1 with registered start_q=0. On detection in IDLE:
  - Latch sub.
  - Copy A into working shift register SA, and B or ~B into SB.
  - Carry ← sub.
  - Digit counter ← 0; clear done; busy ← 1; go to RUN.
- Start and load at the same edge: start wins and the loads are ignored.
- RUN, each cycle:
  - Add the low DIGIT bits of SA, SB and carry.
  - Shift the sum digit into the working result from the MSB side.
  - Shift SA and SB right by DIGIT.
  - Update carry and increment the counter.
- After WIDTH/DIGIT digits:
  - uo_out ← working result.
  - Carry flag ← final carry.
  - busy ← 0, done ← 1, return to IDLE.
- uo_out and the carry flag hold their previous values throughout RUN and change only on completion.
- Ignored in RUN: load_a, load_b, start edges and sub changes. start_q always tracks start, so a start held high from RUN into IDLE does not retrigger.
- done holds until the next accepted start or load.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement (~B plus carry-in 1).

## Timing
- Reset (asynchronous assert, any state, including mid-RUN):
  - State IDLE.
  - A, B, SA, SB, counter, start_q: 0.
  - uo_out: 0x00; uio_out: 0x00 (busy, done, carry, ovf all 0).
  - No operation resumes after release.
- Start seen at edge T:
  - busy=1 visible after T.
  - Result, carry and done=1 visible after edge T+WIDTH/DIGIT.
  - busy=0 at that same edge.
- Earliest next start edge is T+WIDTH/DIGIT+1, since it needs a low-then-high start.
- Load to start: a load at edge T may be followed by start at T+1.

## Configuration
- `SADD_OVF_EN` defined:
  - uio[4] becomes an output, and uio_oe[4]=1.
  - uio_out[4] = signed overflow of the last result:
    - add: operand signs equal and result sign differs;
    - sub: operand signs differ and result sign differs from A's sign.
  - Updated at completion; cleared by reset, start and loads.
- `SADD_OVF_EN` undefined: uio_out[4]=0, uio_oe[4]=0, and there is no overflow logic.

## Test plan
- Reset with rst_n=0 → uo_out=0x00, uio_out=0x00, uio_oe=0xE0 (0xF0 with macro). Repeat with rst_n asserted mid-RUN at digit 3 → same values; no done afterwards.
- WIDTH=8, DIGIT=1; load A=0x05, B=0x03; start with sub=0 → busy for exactly 8 cycles, then uo_out=0x08, carry=0, done=1.
- A=0xFF, B=0x01, add → uo_out=0x00, carry=1.
- A=0x03, B=0x05, sub=1 → uo_out=0xFE, carry=0. Then A=0x05, B=0x03, sub → 0x02, carry=1.
- With macro: A=0x7F, B=0x01, add → uo_out=0x80, ovf=1. A=0x80, B=0x01, sub → 0x7F, ovf=1.
- Start re-pulsed and loads toggled during RUN → no effect on the result or latency. Start held high after done → no second run.
- WIDTH=8, DIGIT=4: A=0x9C, B=0x64 → done after 2 cycles, uo_out=0x00, carry=1.
- WIDTH=4, DIGIT=2: A=0xF, B=0x2 → uo_out=0x01, carry=1, with uo_out[7:4]=0.
